// File: rtl/otter_icache_if.sv
// Refill bus between otter_icache (master) and the backing instruction memory (slave).
// One request per line, then WORDS data beats in word order.
interface otter_icache_if;
   logic        MEM_REQ;
   logic [31:0] MEM_ADDR;
   logic        MEM_ACK;
   logic        MEM_RVALID;
   logic [31:0] MEM_RDATA;

   modport master (output MEM_REQ, MEM_ADDR, input MEM_ACK, MEM_RVALID, MEM_RDATA);
   modport slave  (input MEM_REQ, MEM_ADDR, output MEM_ACK, MEM_RVALID, MEM_RDATA);
endinterface

// File: rtl/otter_icache.sv
// Direct-mapped instruction cache for the OTTER fetch stage: combinational hit path,
// line refill over otter_icache_if, whole-cache invalidate and hit/miss counters.
module otter_icache #(
   parameter int          LINES = 16,
   parameter int          WORDS = 8,
   parameter logic [31:0] NOP   = 32'h00000013
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [31:0]        PC,
   input  logic               RD_EN,
   output logic [31:0]        IR,
   output logic               HIT,
   output logic               PC_STALL,
   input  logic               INVALIDATE,
   otter_icache_if.master     mem,
   output logic [31:0]        HIT_CNT,
   output logic [31:0]        MISS_CNT
);
   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - OFF_W - IDX_W;

   typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
   } line_t;

   state_t           state, nxt;
   line_t            req_q;
   logic [LINES-1:0] valid;
   logic             pend;
   logic [OFF_W-1:0] beat;
   logic [TAG_W-1:0] tag_arr  [LINES];
   logic [31:0]      data_arr [LINES*WORDS];

   logic [OFF_W-1:0] pc_off;
   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic             miss_start, last_beat;
   logic             unused_pc;

   assign pc_off     = PC[2 +: OFF_W];
   assign pc_idx     = PC[2+OFF_W +: IDX_W];
   assign pc_tag     = PC[31 -: TAG_W];
   assign unused_pc  = ^PC[1:0];
   assign miss_start = (state == IDLE) && RD_EN && !HIT;
   assign last_beat  = mem.MEM_RVALID && (beat == OFF_W'(WORDS-1));
   assign mem.MEM_ADDR = {req_q, {(OFF_W+2){1'b0}}};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (miss_start)      nxt = REQ;
         REQ:     if (mem.MEM_ACK)     nxt = FILL;
         FILL:    if (last_beat)       nxt = DONE;
         DONE:                         nxt = IDLE;
         default:                      nxt = IDLE;
      endcase
   end

   always_comb begin
      HIT         = (state == IDLE) && valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
      IR          = HIT ? data_arr[{pc_idx, pc_off}] : NOP;
      PC_STALL    = (RD_EN && !HIT) || (state != IDLE);
      mem.MEM_REQ = (state == REQ);
   end

   // Later assignments win: an invalidate overrides both the miss clear and the DONE set.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         req_q    <= '0;
         valid    <= '0;
         pend     <= 1'b0;
         beat     <= '0;
         HIT_CNT  <= '0;
         MISS_CNT <= '0;
      end else begin
         if (miss_start) begin
            req_q         <= '{tag: pc_tag, idx: pc_idx};
            valid[pc_idx] <= 1'b0;
            MISS_CNT      <= MISS_CNT + 32'd1;
         end
         if (RD_EN && HIT)                  HIT_CNT <= HIT_CNT + 32'd1;
         if (state == DONE && !pend)        valid[req_q.idx] <= 1'b1;
         if (INVALIDATE)                    valid <= '0;
         if (state == DONE)                 pend <= 1'b0;
         else if (INVALIDATE && (state == REQ || state == FILL)) pend <= 1'b1;
         if (state == REQ && mem.MEM_ACK)   beat <= '0;
         else if (state == FILL && mem.MEM_RVALID) beat <= beat + 1'b1;
      end
   end

   // Tag and data storage carry no reset; validity alone decides a hit.
   always_ff @(posedge CLK) begin
      if (state == FILL && mem.MEM_RVALID) data_arr[{req_q.idx, beat}] <= mem.MEM_RDATA;
      if (state == DONE)                   tag_arr[req_q.idx] <= req_q.tag;
   end
endmodule

// File: tb/tb_otter_icache.sv
// Directed vector bench for otter_icache plus two small-/large-geometry instances
// checked against a reference memory on a random address stream.
module tb_otter_icache;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [31:0] pc = '0;
   logic        rd_en = 1'b0, inv = 1'b0;
   logic [31:0] ir, hcnt, mcnt;
   logic        hit, stall;
   int          total = 0, bad = 0;

   always #5 CLK = ~CLK;

   otter_icache_if mif();
   otter_icache #(.LINES(16), .WORDS(8), .NOP(NOP)) dut (
      .CLK(CLK), .RST_N(RST_N), .PC(pc), .RD_EN(rd_en), .IR(ir), .HIT(hit),
      .PC_STALL(stall), .INVALIDATE(inv), .mem(mif), .HIT_CNT(hcnt), .MISS_CNT(mcnt));

   // ---------------- sweep instances with a reference memory ----------------
   function automatic logic [31:0] mdl(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h13579BDF;
   endfunction

   logic        rs_n = 1'b0;
   logic [31:0] pa = '0, pb = '0, ira, irb, hca, mca, hcb, mcb;
   logic        ra = 1'b0, rb = 1'b0, ha, hb, sa, sb;
   logic [31:0] ka = '0, kb = '0;

   otter_icache_if ifa();
   otter_icache_if ifb();
   assign ifa.MEM_ACK    = ifa.MEM_REQ;
   assign ifa.MEM_RVALID = 1'b1;
   assign ifa.MEM_RDATA  = mdl(ifa.MEM_ADDR + (ka << 2));
   assign ifb.MEM_ACK    = ifb.MEM_REQ;
   assign ifb.MEM_RVALID = 1'b1;
   assign ifb.MEM_RDATA  = mdl(ifb.MEM_ADDR + (kb << 2));
   // Beat k of a burst is the k-th cycle after the accepting cycle.
   always @(posedge CLK) begin
      if (ifa.MEM_REQ && ifa.MEM_ACK) ka <= '0; else ka <= ka + 32'd1;
      if (ifb.MEM_REQ && ifb.MEM_ACK) kb <= '0; else kb <= kb + 32'd1;
   end

   otter_icache #(.LINES(2), .WORDS(2), .NOP(NOP)) dut_a (
      .CLK(CLK), .RST_N(rs_n), .PC(pa), .RD_EN(ra), .IR(ira), .HIT(ha), .PC_STALL(sa),
      .INVALIDATE(1'b0), .mem(ifa), .HIT_CNT(hca), .MISS_CNT(mca));
   otter_icache #(.LINES(64), .WORDS(16), .NOP(NOP)) dut_b (
      .CLK(CLK), .RST_N(rs_n), .PC(pb), .RD_EN(rb), .IR(irb), .HIT(hb), .PC_STALL(sb),
      .INVALIDATE(1'b0), .mem(ifb), .HIT_CNT(hcb), .MISS_CNT(mcb));

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] pc;
      logic        rd, inv, ack, rv;
      logic [31:0] rdata;
      logic        ehit;
      logic [31:0] eir;
      logic        estall, ereq;
      logic [31:0] eaddr;
   } vec_t;
   vec_t rows[$];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic rd, input logic iv, input logic ak,
                       input logic rv, input logic [31:0] rdat, input logic eh,
                       input logic [31:0] ei, input logic es, input logic er, input logic [31:0] ea);
      vec_t v;
      v = '{pc: a, rd: rd, inv: iv, ack: ak, rv: rv, rdata: rdat, ehit: eh, eir: ei,
            estall: es, ereq: er, eaddr: ea};
      rows.push_back(v);
   endtask

   // Miss cycle, REQ (ack after ad extra cycles), 8 beats with gap idle cycles before
   // each, DONE. inv_at: beat index for an invalidate pulse, 8 = on DONE, -1 = none.
   task automatic miss_fill(input logic [31:0] a, input logic [31:0] d0, input int ad,
                            input int gap, input int inv_at);
      push(a, 1, 0, 0, 0, 0, 0, NOP, 1, 0, 0);
      for (int r = 0; r <= ad; r++) push(a, 1, 0, r == ad, 0, 0, 0, NOP, 1, 1, a & ~32'h1F);
      for (int i = 0; i < 8; i++) begin
         for (int g = 0; g < gap; g++) push(a, 1, 0, 0, 0, 32'hDEADBEEF, 0, NOP, 1, 0, 0);
         push(a, 1, inv_at == i, 0, 1, d0 + i, 0, NOP, 1, 0, 0);
      end
      push(a, 1, inv_at == 8, 0, 0, 0, 0, NOP, 1, 0, 0);
   endtask

   task automatic hit_row(input logic [31:0] a, input logic [31:0] w);
      push(a, 1, 0, 0, 0, 0, 1, w, 0, 0, 0);
   endtask

   task automatic run_rows(input string nm);
      for (int i = 0; i < rows.size(); i++) begin
         @(posedge CLK); #1;
         pc = rows[i].pc; rd_en = rows[i].rd; inv = rows[i].inv;
         mif.MEM_ACK = rows[i].ack; mif.MEM_RVALID = rows[i].rv; mif.MEM_RDATA = rows[i].rdata;
         #2;
         chk({nm, ".hit"},   i, 32'(hit),   32'(rows[i].ehit));
         chk({nm, ".ir"},    i, ir,         rows[i].eir);
         chk({nm, ".stall"}, i, 32'(stall), 32'(rows[i].estall));
         chk({nm, ".req"},   i, 32'(mif.MEM_REQ), 32'(rows[i].ereq));
         if (rows[i].ereq) chk({nm, ".addr"}, i, mif.MEM_ADDR, rows[i].eaddr);
      end
      rows.delete();
   endtask

   task automatic check_cnt(input string nm, input logic [31:0] eh, input logic [31:0] em);
      @(posedge CLK); #1;
      rd_en = 0; inv = 0; mif.MEM_ACK = 0; mif.MEM_RVALID = 0;
      #2;
      chk({nm, ".hit_cnt"},  0, hcnt, eh);
      chk({nm, ".miss_cnt"}, 0, mcnt, em);
   endtask

   task automatic do_reset(input string nm);
      @(posedge CLK); #1;
      RST_N = 0; pc = 32'h100; rd_en = 1; inv = 0;
      mif.MEM_ACK = 0; mif.MEM_RVALID = 0; mif.MEM_RDATA = 0;
      #1;
      chk({nm, ".rst_hit"},   0, 32'(hit), 0);
      chk({nm, ".rst_ir"},    0, ir, NOP);
      chk({nm, ".rst_stall"}, 0, 32'(stall), 1);
      chk({nm, ".rst_req"},   0, 32'(mif.MEM_REQ), 0);
      chk({nm, ".rst_addr"},  0, mif.MEM_ADDR, 0);
      chk({nm, ".rst_hcnt"},  0, hcnt, 0);
      chk({nm, ".rst_mcnt"},  0, mcnt, 0);
      rd_en = 0; #1;
      chk({nm, ".rst_stall0"}, 0, 32'(stall), 0);
      @(posedge CLK); #1;
      RST_N = 1;
   endtask

   task automatic sweep(input int which, input int n, input int range);
      logic [31:0] a;
      logic        h, got;
      for (int k = 0; k < n; k++) begin
         a = 32'($urandom_range(0, range)) & ~32'h3;
         @(posedge CLK); #1;
         if (which == 0) begin pa = a; ra = 1; end else begin pb = a; rb = 1; end
         #1;
         got = 0;
         for (int w = 0; w < 80 && !got; w++) begin
            h = (which == 0) ? ha : hb;
            if (h) begin
               chk(which == 0 ? "sweep2x2.ir" : "sweep64x16.ir", k, which == 0 ? ira : irb, mdl(a));
               got = 1;
            end else begin
               @(posedge CLK); #2;
            end
         end
         if (!got) chk(which == 0 ? "sweep2x2.timeout" : "sweep64x16.timeout", k, 0, 1);
      end
      ra = 0; rb = 0;
   endtask

   initial begin
      mif.MEM_ACK = 0; mif.MEM_RVALID = 0; mif.MEM_RDATA = 0;

      // Cold miss then eight sequential hits.
      do_reset("cold");
      miss_fill(32'h100, 32'hA0, 0, 0, -1);
      for (int k = 0; k < 8; k++) hit_row(32'h100 + 4*k, 32'hA0 + k);
      run_rows("cold");
      check_cnt("cold", 8, 1);

      // Delayed ACK (four REQ cycles) and a beat every other cycle.
      do_reset("gap");
      miss_fill(32'h140, 32'hB0, 3, 1, -1);
      for (int k = 7; k >= 0; k--) hit_row(32'h140 + 4*k, 32'hB0 + k);
      run_rows("gap");
      check_cnt("gap", 8, 1);

      // Two tags competing for index 0.
      do_reset("conflict");
      miss_fill(32'h000, 32'hC0, 0, 0, -1);
      hit_row(32'h000, 32'hC0);
      miss_fill(32'h200, 32'hD0, 0, 0, -1);
      hit_row(32'h204, 32'hD1);
      miss_fill(32'h000, 32'hE0, 0, 0, -1);
      hit_row(32'h000, 32'hE0);
      hit_row(32'h01C, 32'hE7);
      run_rows("conflict");
      check_cnt("conflict", 4, 3);

      // Invalidate during beat 4: refill completes but the line stays invalid.
      do_reset("inv_fill");
      miss_fill(32'h100, 32'hA0, 0, 0, 4);
      push(32'h100, 1, 0, 0, 0, 0, 0, NOP, 1, 0, 0);
      push(32'h100, 1, 0, 0, 0, 0, 0, NOP, 1, 1, 32'h100);
      run_rows("inv_fill");
      check_cnt("inv_fill", 0, 2);

      // Invalidate on DONE beats the valid write; invalidate in IDLE drops a live line.
      do_reset("inv_idle");
      miss_fill(32'h180, 32'h30, 0, 0, 8);
      push(32'h180, 1, 0, 0, 0, 0, 0, NOP, 1, 0, 0);
      push(32'h180, 1, 0, 1, 0, 0, 0, NOP, 1, 1, 32'h180);
      for (int i = 0; i < 8; i++) push(32'h180, 1, 0, 0, 1, 32'h40 + i, 0, NOP, 1, 0, 0);
      push(32'h180, 1, 0, 0, 0, 0, 0, NOP, 1, 0, 0);
      hit_row(32'h184, 32'h41);
      push(32'h184, 0, 1, 0, 0, 0, 1, 32'h41, 0, 0, 0);
      push(32'h184, 1, 0, 0, 0, 0, 0, NOP, 1, 0, 0);
      run_rows("inv_idle");
      check_cnt("inv_idle", 1, 3);

      // Reset in the middle of a refill after a line had become valid.
      do_reset("rst_mid");
      miss_fill(32'h100, 32'hA0, 0, 0, -1);
      hit_row(32'h100, 32'hA0);
      push(32'h240, 1, 0, 0, 0, 0, 0, NOP, 1, 0, 0);
      push(32'h240, 1, 0, 1, 0, 0, 0, NOP, 1, 1, 32'h240);
      for (int i = 0; i < 3; i++) push(32'h240, 1, 0, 0, 1, 32'h70 + i, 0, NOP, 1, 0, 0);
      run_rows("rst_mid");
      do_reset("rst_mid2");
      push(32'h100, 1, 0, 0, 0, 0, 0, NOP, 1, 0, 0);
      push(32'h100, 1, 0, 0, 0, 0, 0, NOP, 1, 1, 32'h100);
      run_rows("rst_mid3");

      // Geometry sweep against the reference memory.
      @(posedge CLK); #1 rs_n = 1;
      sweep(0, 40, 127);
      sweep(1, 40, 16383);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
